steering_phase_generator: RTL and testbench
===========================================

# steering_phase_generator

Inverse of the localization direction stage. Takes one direction vector (x, y, 5.11 fixed point, same packing the direction calculator emits) and sweeps all frequency bins, emitting for each bin the expected phase of each peripheral microphone relative to the central one, wrapped to [-pi, pi] in 3.13. It feeds the beamforming/validation path, which compares predicted and measured per-bin phases. It works by incremental phase accumulation, so it needs no per-bin multiplier.

## Interface
- N_BINS, 512: bins per sweep; output bin index runs 0..N_BINS-1
- STEP_GAIN, 16'h1000: unsigned 3.13 phase advance per bin per unit of projected distance
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- dir_in  input  32  direction {x[31:16], y[15:0]}, each signed 5.11
- dir_valid_in  input  1  direction offered
- dir_ready_out  output  1  high only in IDLE
- phases_out  output  3x16  signed 3.13 predicted phase per peripheral mic (index 0..2)
- bin_out  output  $clog2(N_BINS)  bin index of current phases_out
- valid_out  output  1  phases_out/bin_out valid
- ready_in  input  1  downstream accepts
- last_out  output  1  high with valid_out on bin N_BINS-1
- busy_out  output  1  high in PREP or SWEEP

## Operation
- Mic geometry (fixed): mic0 (0,1), mic1 (-1,-1), mic2 (1,-1). Projections: d0 = y, d1 = -x-y, d2 = x-y, each 18-bit signed 7.11, sign-extended before adding.
- Step: s_i = (d_i * STEP_GAIN) >>> 11 (full-width signed product, arithmetic shift), then clamped to [-16'h6488, +16'h6488] (±pi). Stored as 16-bit signed.
- Accumulator per mic, 16-bit signed. It starts at 0 for bin 0. On each output handshake: t = acc + s_i, computed in 17 bits. If t > 16'h6488, t -= 17'hC910. Else if t < -16'h6488, t += 17'hC910. acc = t[15:0]. A single correction always suffices because |acc| ≤ pi and |s| ≤ pi.
- FSM:
  - IDLE: dir_ready_out=1. On dir_valid_in && dir_ready_out, latch dir_in and go to PREP.
  - PREP: compute and register s_i, clear accumulators and bin counter, go to SWEEP.
  - SWEEP: valid_out=1. On valid_out && ready_in: if bin_out == N_BINS-1, go to IDLE; otherwise bin++ and accumulators advance.
- Outputs are held stable while valid_out && !ready_in.
- last_out = valid_out && (bin_out == N_BINS-1).
- dir_valid_in is ignored outside IDLE. No queueing; an upstream direction stays pending.

## Timing
- Reset (asynchronous assert, any state): state IDLE; phases_out=0, bin_out=0, valid_out=0, last_out=0, busy_out=0, dir_ready_out=1; latched direction and steps cleared. Reset mid-sweep aborts the sweep with no further output.
- Direction accepted at edge E0 → PREP during the next cycle. valid_out rises after edge E1 with bin 0 and phases all 0. Latency from accept to first valid: 2 cycles.
- With ready_in held high, one bin is emitted per cycle. A full sweep takes N_BINS cycles after PREP.
- Final handshake at edge En: after En, valid_out=0, last_out=0, dir_ready_out=1. The next direction can be accepted at En+1 at the earliest, giving a 1-cycle IDLE gap between sweeps.
- Backpressure: ready_in low freezes the bin counter, accumulators and outputs with no loss. ready_in toggling every cycle emits one bin per two cycles.
- Wrap boundaries: exactly +16'h6488 or -16'h6488 is not corrected; only strict exceedance is.
- Step clamp applies symmetrically. A zero direction gives all phases 0 for every bin.

## Test plan
- Reset then idle: dir_valid_in=0 → dir_ready_out=1, valid_out=0, busy_out=0 indefinitely. Assert rst_in mid-sweep at bin 37 → all outputs return to reset values in the same cycle, with no further valid.
- dir_in={16'h0000,16'h0800} (x=0, y=1.0), STEP_GAIN=16'h1000, ready_in=1 → bin0: 0,0,0. Bin1: 16'h1000, 16'hF000, 16'hF000. Bin6: 16'h6000, 16'hA000, 16'hA000. Bin7: 16'hA6F0 (0x7000 wrapped), 16'h5910, 16'h5910. First valid 2 cycles after accept.
- Clamp: dir_in={16'h0000,16'h2000} (y=4.0), STEP_GAIN=16'h6000 → s0 clamped to 16'h6488. Bin1 phase0 = 16'h6488 (not wrapped). Bin2 phase0 = 16'h6488+16'h6488-16'hC910 = 0.
- Backpressure: ready_in low for 5 cycles at bin 3 → bin_out=3 and phases_out held constant. Resuming gives bin 4 with the correct values. The total count of handshakes equals N_BINS.
- Sweep end and back-to-back: dir_valid_in held high throughout → last_out high only on bin N_BINS-1. The second direction is accepted exactly one cycle after the final handshake, and dir_valid_in is ignored during the sweep.
- Zero direction dir_in=0 → every bin outputs phases 0,0,0. last_out asserts on bin N_BINS-1.

Source files
------------

// File: rtl/steering_phase_generator.sv
// Steering phase generator: sweeps all frequency bins for one direction vector and
// emits the wrapped expected phase of each peripheral mic via incremental accumulation.
module steering_phase_generator #(
    parameter int unsigned N_BINS    = 512,
    parameter logic [15:0] STEP_GAIN = 16'h1000
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [31:0]                 dir_in,
    input  logic                        dir_valid_in,
    output logic                        dir_ready_out,
    output logic [2:0][15:0]            phases_out,
    output logic [$clog2(N_BINS)-1:0]   bin_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        last_out,
    output logic                        busy_out
);

    localparam int unsigned BIN_W = $clog2(N_BINS);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_BINS - 1);
    localparam logic signed [15:0] PI_Q   = 16'sh6488;
    localparam logic signed [16:0] TWO_PI = 17'sd51472;
    localparam logic signed [16:0] GAIN_S = $signed({1'b0, STEP_GAIN});

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t             state_q, state_nxt;
    logic               accept_c, fire_c, done_c;
    logic [BIN_W-1:0]   bin_nxt;
    logic [31:0]        dir_q;
    logic [2:0][15:0]   step_q;
    logic signed [17:0] dx, dy;
    logic signed [17:0] proj [3];

    // Per-bin phase step for one projection, saturated to +-pi
    function automatic logic [15:0] calc_step(input logic signed [17:0] d);
        logic signed [34:0] prod;
        prod = 35'(d) * 35'(GAIN_S);
        prod = prod >>> 11;
        if (prod > 35'sd25736)
            return PI_Q;
        else if (prod < -35'sd25736)
            return -PI_Q;
        return prod[15:0];
    endfunction

    // One accumulation step with a single 2*pi correction back into [-pi, pi]
    function automatic logic [15:0] wrap_add(input logic [15:0] a, input logic [15:0] s);
        logic signed [16:0] t;
        t = 17'($signed(a)) + 17'($signed(s));
        if (t > 17'sd25736)
            t = t - TWO_PI;
        else if (t < -17'sd25736)
            t = t + TWO_PI;
        return t[15:0];
    endfunction

    always_comb begin
        dx      = 18'($signed(dir_q[31:16]));
        dy      = 18'($signed(dir_q[15:0]));
        proj[0] = dy;
        proj[1] = -dx - dy;
        proj[2] = dx - dy;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        accept_c  = 1'b0;
        fire_c    = 1'b0;
        done_c    = 1'b0;
        bin_nxt   = bin_out;
        case (state_q)
            IDLE: begin
                if (dir_valid_in) begin
                    accept_c  = 1'b1;
                    state_nxt = PREP;
                end
            end
            PREP: begin
                bin_nxt   = '0;
                state_nxt = SWEEP;
            end
            SWEEP: begin
                if (ready_in) begin
                    fire_c = 1'b1;
                    if (bin_out == LAST_BIN) begin
                        done_c    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        bin_nxt = bin_out + BIN_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they align with bin_out
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dir_ready_out <= 1'b1;
            busy_out      <= 1'b0;
            valid_out     <= 1'b0;
            last_out      <= 1'b0;
        end else begin
            dir_ready_out <= (state_nxt == IDLE);
            busy_out      <= (state_nxt != IDLE);
            valid_out     <= (state_nxt == SWEEP);
            last_out      <= (state_nxt == SWEEP) && (bin_nxt == LAST_BIN);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dir_q      <= '0;
            step_q     <= '0;
            phases_out <= '0;
            bin_out    <= '0;
        end else begin
            bin_out <= bin_nxt;
            if (accept_c)
                dir_q <= dir_in;
            if (state_q == PREP) begin
                for (int i = 0; i < 3; i++)
                    step_q[i] <= calc_step(proj[i]);
                phases_out <= '0;
            end
            if (fire_c && !done_c) begin
                for (int i = 0; i < 3; i++)
                    phases_out[i] <= wrap_add(phases_out[i], step_q[i]);
            end
        end
    end

endmodule

// File: tb/tb_steering_phase_generator.sv
// Randomized self-checking bench for steering_phase_generator against an integer phase model.
module tb_steering_phase_generator;

    localparam int unsigned N_BINS = 512;
    localparam int unsigned BIN_W  = $clog2(N_BINS);
    localparam logic [15:0] GAIN   = 16'h1000;
    localparam int PI_I     = 25736;
    localparam int TWO_PI_I = 51472;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [31:0]      dir_in;
    logic             dir_valid_in;
    logic             dir_ready_out;
    logic [2:0][15:0] phases_out;
    logic [BIN_W-1:0] bin_out;
    logic             valid_out;
    logic             ready_in;
    logic             last_out;
    logic             busy_out;

    int checks   = 0;
    int failures = 0;
    logic [2:0][15:0] cap [N_BINS];

    steering_phase_generator #(.N_BINS(N_BINS), .STEP_GAIN(GAIN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .dir_in(dir_in), .dir_valid_in(dir_valid_in),
        .dir_ready_out(dir_ready_out), .phases_out(phases_out), .bin_out(bin_out),
        .valid_out(valid_out), .ready_in(ready_in), .last_out(last_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Phase advance per bin: projected distance times gain, rescaled, saturated at +-pi
    function automatic int model_step(input int d);
        longint p;
        p = longint'(d) * longint'(GAIN);
        p = p >>> 11;
        if (p > PI_I)  p = PI_I;
        if (p < -PI_I) p = -PI_I;
        return int'(p);
    endfunction

    function automatic int model_adv(input int a, input int s);
        int t;
        t = a + s;
        if (t > PI_I)       t = t - TWO_PI_I;
        else if (t < -PI_I) t = t + TWO_PI_I;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Runs one full sweep; mode 0 ready high, 1 random, 2 toggling, 3 stall 5 cycles at bin 3
    task automatic sweep(input logic signed [15:0] x, input logic signed [15:0] y,
                         input int mode, input bit hold);
        int s [3];
        int acc [3];
        int k, hs, cyc, stall;
        bit done;
        logic [2:0][15:0] exp_ph;
        s[0] = model_step(int'(y));
        s[1] = model_step(-int'(x) - int'(y));
        s[2] = model_step(int'(x) - int'(y));
        dir_in       = {x, y};
        dir_valid_in = 1'b1;
        checks++;
        if (dir_ready_out !== 1'b1 || busy_out !== 1'b0)
            $display("FAIL accept_ready: dir_ready_out=%b busy_out=%b required 1 0", dir_ready_out, busy_out);
        tick();
        if (hold) dir_in = $urandom();
        else      dir_valid_in = 1'b0;
        checks++;
        if (busy_out !== 1'b1 || valid_out !== 1'b0 || dir_ready_out !== 1'b0) begin
            failures++;
            $display("FAIL prep_state: busy=%b valid=%b ready=%b required 1 0 0", busy_out, valid_out, dir_ready_out);
        end
        tick();
        acc = '{0, 0, 0};
        k = 0; hs = 0; cyc = 0; stall = 5; done = 1'b0;
        while (!done && cyc < 8 * int'(N_BINS)) begin
            exp_ph = {16'(acc[2]), 16'(acc[1]), 16'(acc[0])};
            checks++;
            if (valid_out !== 1'b1 || bin_out !== BIN_W'(k) || phases_out !== exp_ph ||
                last_out !== (k == int'(N_BINS) - 1) || dir_ready_out !== 1'b0) begin
                failures++;
                $display("FAIL sweep_bin: valid=%b bin=%0d ph=%h last=%b ready=%b required 1 %0d %h %b 0",
                         valid_out, bin_out, phases_out, last_out, dir_ready_out, k, exp_ph,
                         (k == int'(N_BINS) - 1));
            end
            cap[k] = phases_out;
            case (mode)
                1:       ready_in = 1'($urandom_range(0, 1));
                2:       ready_in = (cyc % 2 == 0);
                3: begin
                    if (k == 3 && stall > 0) begin
                        ready_in = 1'b0;
                        stall--;
                    end else begin
                        ready_in = 1'b1;
                    end
                end
                default: ready_in = 1'b1;
            endcase
            tick();
            cyc++;
            if (ready_in) begin
                hs++;
                if (k == int'(N_BINS) - 1) begin
                    done = 1'b1;
                end else begin
                    k++;
                    for (int i = 0; i < 3; i++) acc[i] = model_adv(acc[i], s[i]);
                end
            end
        end
        ready_in = 1'b1;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL sweep_timeout: handshakes=%0d required %0d", hs, N_BINS);
            dir_valid_in = 1'b0;
            rst_in = 1'b1;
            tick();
            rst_in = 1'b0;
            tick();
        end else if (valid_out !== 1'b0 || last_out !== 1'b0 || dir_ready_out !== 1'b1 ||
                     busy_out !== 1'b0 || hs != int'(N_BINS)) begin
            failures++;
            $display("FAIL sweep_end: valid=%b last=%b ready=%b busy=%b hs=%0d required 0 0 1 0 %0d",
                     valid_out, last_out, dir_ready_out, busy_out, hs, N_BINS);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; dir_in = '0; dir_valid_in = 1'b0; ready_in = 1'b1;
        #12;
        checks++;
        if (valid_out !== 1'b0 || last_out !== 1'b0 || busy_out !== 1'b0 || dir_ready_out !== 1'b1 ||
            phases_out !== '0 || bin_out !== '0) begin
            failures++;
            $display("FAIL reset_values: valid=%b last=%b busy=%b ready=%b ph=%h bin=%0d required 0 0 0 1 0 0",
                     valid_out, last_out, busy_out, dir_ready_out, phases_out, bin_out);
        end
        tick();
        rst_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (dir_ready_out !== 1'b1 || valid_out !== 1'b0 || busy_out !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold: ready=%b valid=%b busy=%b required 1 0 0", dir_ready_out, valid_out, busy_out);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        found = 1'b0;
        dir_in = {16'h0000, 16'h0800};
        dir_valid_in = 1'b1;
        ready_in = 1'b1;
        tick();
        dir_valid_in = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (valid_out === 1'b1 && bin_out === BIN_W'(37)) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reach_bin37: bin=%0d valid=%b required 37 1", bin_out, valid_out);
        end
        rst_in = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b0 || last_out !== 1'b0 || busy_out !== 1'b0 || dir_ready_out !== 1'b1 ||
            phases_out !== '0 || bin_out !== '0) begin
            failures++;
            $display("FAIL mid_reset: valid=%b last=%b busy=%b ready=%b ph=%h bin=%0d required 0 0 0 1 0 0",
                     valid_out, last_out, busy_out, dir_ready_out, phases_out, bin_out);
        end
        tick();
        rst_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (valid_out !== 1'b0 || busy_out !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_quiet: valid=%b busy=%b required 0 0", valid_out, busy_out);
            end
        end
    endtask

    task automatic test_basic();
        sweep(16'sh0000, 16'sh0800, 0, 1'b0);
        checks++;
        if (cap[0] !== 48'h0000_0000_0000 || cap[1] !== {16'hF000, 16'hF000, 16'h1000}) begin
            failures++;
            $display("FAIL basic_bin01: got %h %h required 0 f000f0001000", cap[0], cap[1]);
        end
        checks++;
        if (cap[6] !== {16'hA000, 16'hA000, 16'h6000} || cap[7] !== {16'h5910, 16'h5910, 16'hA6F0}) begin
            failures++;
            $display("FAIL basic_wrap: got %h %h required a000a0006000 59105910a6f0", cap[6], cap[7]);
        end
    endtask

    task automatic test_clamp();
        sweep(16'sh0000, 16'sh7800, 0, 1'b0);
        checks++;
        if (cap[1] !== {16'h9B78, 16'h9B78, 16'h6488} || cap[2] !== '0 || cap[3][0] !== 16'h6488) begin
            failures++;
            $display("FAIL clamp_edge: got %h %h %h required 9b789b786488 0 6488", cap[1], cap[2], cap[3][0]);
        end
    endtask

    task automatic test_backpressure();
        sweep(16'sh0000, 16'sh0800, 3, 1'b0);
        checks++;
        if (cap[4] !== {16'hC000, 16'hC000, 16'h4000}) begin
            failures++;
            $display("FAIL bp_resume: got %h required c000c0004000", cap[4]);
        end
        sweep(16'($urandom), 16'($urandom), 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        sweep(16'sh0800, 16'sh0400, 0, 1'b1);
        sweep(16'shF800, 16'sh0C00, 0, 1'b0);
    endtask

    task automatic test_zero();
        int nz;
        nz = 0;
        sweep(16'sh0000, 16'sh0000, 1, 1'b0);
        for (int i = 0; i < int'(N_BINS); i++) if (cap[i] !== '0) nz++;
        checks++;
        if (nz != 0) begin
            failures++;
            $display("FAIL zero_dir: nonzero_bins=%0d required 0", nz);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++)
            sweep(16'($urandom), 16'($urandom), 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_reset_mid_sweep();
        test_basic();
        test_clamp();
        test_backpressure();
        test_back_to_back();
        test_zero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
